// File: rtl/line_raster_pkg.sv
// Shared types and default geometry for the line raster engine.
// Optional screen clipping is enabled by defining LINE_RASTER_SCREEN_CLIP_EN.
package line_raster_pkg;

    localparam int DEF_H_RES   = 640;
    localparam int DEF_V_RES   = 480;
    localparam int DEF_COORD_W = 10;
    localparam int DEF_COLOR_W = 3;

    // Descriptor storage is sized for the widest supported build; narrower
    // builds zero-extend into it and read back only the low bits.
    localparam int DESC_COORD_W = 16;
    localparam int DESC_COLOR_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ACCEPT = 3'd2,
        SETUP  = 3'd3,
        DRAW   = 3'd4
    } state_t;

    typedef struct packed {
        logic [DESC_COORD_W-1:0] x0;
        logic [DESC_COORD_W-1:0] y0;
        logic [DESC_COORD_W-1:0] x1;
        logic [DESC_COORD_W-1:0] y1;
        logic [DESC_COLOR_W-1:0] color;
    } line_desc_t;

endpackage

// File: rtl/line_raster_engine_if.sv
// Line descriptor input and frame-buffer pixel output of the raster engine.
// Both channels: a transfer happens on a rising clk edge where valid and ready
// are both high; the sender holds valid and payload stable until that edge.
interface line_raster_if #(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 3
);
    logic               line_valid;
    logic               line_ready;
    logic [COORD_W-1:0] line_x0;
    logic [COORD_W-1:0] line_y0;
    logic [COORD_W-1:0] line_x1;
    logic [COORD_W-1:0] line_y1;
    logic [COLOR_W-1:0] line_color;

    logic               px_valid;
    logic               px_ready;
    logic [COORD_W-1:0] px_x;
    logic [COORD_W-1:0] px_y;
    logic [COLOR_W-1:0] px_color;

    modport master (
        input  line_valid, line_x0, line_y0, line_x1, line_y1, line_color, px_ready,
        output line_ready, px_valid, px_x, px_y, px_color
    );

    modport slave (
        output line_valid, line_x0, line_y0, line_x1, line_y1, line_color, px_ready,
        input  line_ready, px_valid, px_x, px_y, px_color
    );
endinterface

// File: rtl/line_raster_engine_bresenham_step.sv
// One combinational Bresenham step: next point and error term for all octants.
module bresenham_step #(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0]        x,
    input  logic [COORD_W-1:0]        y,
    input  logic signed [COORD_W+1:0] err,
    input  logic [COORD_W-1:0]        dx,
    input  logic [COORD_W-1:0]        dy,
    input  logic                      sx_neg,
    input  logic                      sy_neg,
    output logic [COORD_W-1:0]        x_nxt,
    output logic [COORD_W-1:0]        y_nxt,
    output logic signed [COORD_W+1:0] err_nxt
);
    // e2 = 2*err needs one extra bit over err.
    logic signed [COORD_W+2:0] e2;
    logic signed [COORD_W+2:0] dx_w;
    logic signed [COORD_W+2:0] neg_dy_w;
    logic signed [COORD_W+1:0] dx_e;
    logic signed [COORD_W+1:0] dy_e;
    logic                      step_x;
    logic                      step_y;

    assign e2       = $signed({err, 1'b0});
    assign dx_w     = $signed({3'b000, dx});
    assign neg_dy_w = -$signed({3'b000, dy});
    assign dx_e     = $signed({2'b00, dx});
    assign dy_e     = $signed({2'b00, dy});

    assign step_x = (e2 > neg_dy_w);
    assign step_y = (e2 < dx_w);

    always_comb begin
        x_nxt   = x;
        y_nxt   = y;
        err_nxt = err;
        if (step_x) begin
            err_nxt = err_nxt - dy_e;
            x_nxt   = sx_neg ? (x - 1'b1) : (x + 1'b1);
        end
        if (step_y) begin
            err_nxt = err_nxt + dx_e;
            y_nxt   = sy_neg ? (y - 1'b1) : (y + 1'b1);
        end
    end
endmodule

// File: rtl/line_raster_engine.sv
// Frame raster engine: optional background clear, then Bresenham lines in all
// octants. Define LINE_RASTER_SCREEN_CLIP_EN to suppress off-screen pixels.
module line_raster_engine
    import line_raster_pkg::*;
#(
    parameter int H_RES   = DEF_H_RES,
    parameter int V_RES   = DEF_V_RES,
    parameter int COORD_W = DEF_COORD_W,
    parameter int COLOR_W = DEF_COLOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] bk_color,
    input  logic               end_of_objects,
    line_raster_if.master      lif,
    output logic               busy,
    output logic               raster_done,
    output state_t             state_dbg
);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

    state_t                    state, state_nxt;
    line_desc_t                desc;
    logic [COLOR_W-1:0]        bk;
    logic [COORD_W-1:0]        cx, cy;
    logic [COORD_W-1:0]        dx, dy;
    logic                      sx_neg, sy_neg;
    logic signed [COORD_W+1:0] err;

    logic [COORD_W-1:0]        d_x0, d_y0, d_x1, d_y1;
    logic [COLOR_W-1:0]        d_color;
    logic [COORD_W-1:0]        dx_c, dy_c;
    logic [COORD_W-1:0]        x_nxt, y_nxt;
    logic signed [COORD_W+1:0] err_nxt;
    logic                      at_end, on_screen;
    logic                      px_valid_c, line_ready_c, clear_adv, draw_adv;
    logic [COLOR_W-1:0]        px_color_c;
    logic                      unused_desc;

    assign d_x0    = desc.x0[COORD_W-1:0];
    assign d_y0    = desc.y0[COORD_W-1:0];
    assign d_x1    = desc.x1[COORD_W-1:0];
    assign d_y1    = desc.y1[COORD_W-1:0];
    assign d_color = desc.color[COLOR_W-1:0];
    // Descriptor bits above the configured widths are always zero.
    assign unused_desc = ^desc;

    assign dx_c   = (d_x1 >= d_x0) ? (d_x1 - d_x0) : (d_x0 - d_x1);
    assign dy_c   = (d_y1 >= d_y0) ? (d_y1 - d_y0) : (d_y0 - d_y1);
    assign at_end = (cx == d_x1) && (cy == d_y1);

`ifdef LINE_RASTER_SCREEN_CLIP_EN
    assign on_screen = (cx <= X_MAX) && (cy <= Y_MAX);
`else
    assign on_screen = 1'b1;
`endif

    bresenham_step #(.COORD_W(COORD_W)) u_step (
        .x       (cx),
        .y       (cy),
        .err     (err),
        .dx      (dx),
        .dy      (dy),
        .sx_neg  (sx_neg),
        .sy_neg  (sy_neg),
        .x_nxt   (x_nxt),
        .y_nxt   (y_nxt),
        .err_nxt (err_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        px_valid_c   = 1'b0;
        line_ready_c = 1'b0;
        raster_done  = 1'b0;
        clear_adv    = 1'b0;
        draw_adv     = 1'b0;
        px_color_c   = '0;
        case (state)
            IDLE: begin
                if (frame_start) state_nxt = clear_req ? CLEAR : ACCEPT;
            end
            CLEAR: begin
                px_valid_c = 1'b1;
                px_color_c = bk;
                if (lif.px_ready) begin
                    clear_adv = 1'b1;
                    if (cx == X_MAX && cy == Y_MAX) state_nxt = ACCEPT;
                end
            end
            ACCEPT: begin
                line_ready_c = 1'b1;
                if (lif.line_valid) begin
                    state_nxt = SETUP;
                end else if (end_of_objects) begin
                    raster_done = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            SETUP: state_nxt = DRAW;
            DRAW: begin
                // Suppressed points step without waiting on the frame buffer.
                px_valid_c = on_screen;
                px_color_c = d_color;
                draw_adv   = on_screen ? lif.px_ready : 1'b1;
                if (draw_adv && at_end) state_nxt = ACCEPT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            desc   <= '0;
            bk     <= '0;
            cx     <= '0;
            cy     <= '0;
            dx     <= '0;
            dy     <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
            err    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start && clear_req) begin
                        bk <= bk_color;
                        cx <= '0;
                        cy <= '0;
                    end
                end
                CLEAR: begin
                    if (clear_adv) begin
                        if (cx == X_MAX) begin
                            cx <= '0;
                            cy <= cy + 1'b1;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end
                ACCEPT: begin
                    if (lif.line_valid) begin
                        desc.x0    <= DESC_COORD_W'(lif.line_x0);
                        desc.y0    <= DESC_COORD_W'(lif.line_y0);
                        desc.x1    <= DESC_COORD_W'(lif.line_x1);
                        desc.y1    <= DESC_COORD_W'(lif.line_y1);
                        desc.color <= DESC_COLOR_W'(lif.line_color);
                    end
                end
                SETUP: begin
                    dx     <= dx_c;
                    dy     <= dy_c;
                    sx_neg <= (d_x1 < d_x0);
                    sy_neg <= (d_y1 < d_y0);
                    err    <= $signed({2'b00, dx_c}) - $signed({2'b00, dy_c});
                    cx     <= d_x0;
                    cy     <= d_y0;
                end
                DRAW: begin
                    if (draw_adv && !at_end) begin
                        cx  <= x_nxt;
                        cy  <= y_nxt;
                        err <= err_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lif.px_valid   = px_valid_c;
    assign lif.line_ready = line_ready_c;
    assign lif.px_x       = cx;
    assign lif.px_y       = cy;
    assign lif.px_color   = px_color_c;
    assign busy           = (state != IDLE);
    assign state_dbg      = state;
endmodule

// File: tb/tb_line_raster_engine.sv
// Directed scoreboard bench for line_raster_engine on an 8x4 screen.
module tb_line_raster_engine;
  import line_raster_pkg::*;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int CW = 10;
  localparam int KW = 3;
  localparam int PW = 2 * CW + KW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic          clear_req = 1'b0;
  logic [KW-1:0] bk_color = '0;
  logic          end_of_objects = 1'b0;
  logic          busy, raster_done;
  state_t        state_dbg;

  line_raster_if #(.COORD_W(CW), .COLOR_W(KW)) lif ();

  line_raster_engine #(.H_RES(H), .V_RES(V), .COORD_W(CW), .COLOR_W(KW)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .clear_req      (clear_req),
    .bk_color       (bk_color),
    .end_of_objects (end_of_objects),
    .lif            (lif.master),
    .busy           (busy),
    .raster_done    (raster_done),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [PW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  bit            sb_en = 1'b1;
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_payload = '0;
  logic [PW-1:0] payload;

  assign payload = {lif.px_x, lif.px_y, lif.px_color};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_px(input int x, input int y, input int c);
    exp_q.push_back({CW'(x), CW'(y), KW'(c)});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && sb_en && lif.px_valid && lif.px_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pixel: got %0h expected none", payload);
      end else begin
        check("pixel", 32'(payload), 32'(exp_q.pop_front()));
      end
    end
  end

  // payload must not move while the frame buffer stalls
  always @(negedge clk) begin
    if (rst && prev_stall && lif.px_valid) check("stall_hold", 32'(payload), 32'(prev_payload));
    prev_stall   = rst && lif.px_valid && !lif.px_ready;
    prev_payload = payload;
  end

  // driver tasks
  task automatic send_line(input int x0, input int y0, input int x1, input int y1,
                           input int c, input bit eoo);
    int t;
    @(posedge clk); #1;
    lif.line_x0    = CW'(x0);
    lif.line_y0    = CW'(y0);
    lif.line_x1    = CW'(x1);
    lif.line_y1    = CW'(y1);
    lif.line_color = KW'(c);
    lif.line_valid = 1'b1;
    end_of_objects = eoo;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!lif.line_ready && t < 200);
    if (!lif.line_ready) check("line_accept_timeout", 32'(lif.line_ready), 32'd1);
    @(posedge clk); #1;
    lif.line_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(nm, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_ready(input string nm);
    int t;
    t = 0;
    while (!lif.line_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(nm, 32'(lif.line_ready), 32'd1);
  endtask

  initial begin
    int t;
    int lx[8] = '{2, 3, 4, 5, 6, 7, 8, 9};
    int ly[8] = '{3, 3, 4, 4, 4, 4, 5, 5};
    int pat[6] = '{1, 0, 0, 1, 1, 1};

    lif.line_valid = 1'b0;
    lif.line_x0    = '0;
    lif.line_y0    = '0;
    lif.line_x1    = '0;
    lif.line_y1    = '0;
    lif.line_color = '0;
    lif.px_ready   = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_px_valid", 32'(lif.px_valid), 32'd0);
    check("rst_line_ready", 32'(lif.line_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_raster_done", 32'(raster_done), 32'd0);
    check("rst_px_xy", 32'({lif.px_x, lif.px_y}), 32'd0);
    check("rst_px_color", 32'(lif.px_color), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b1;

    // background clear in raster order, colour latched at entry
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) push_px(x, y, 5);
    @(posedge clk); #1;
    frame_start = 1'b1;
    clear_req   = 1'b1;
    bk_color    = 3'b101;
    @(posedge clk); #1;
    frame_start = 1'b0;
    clear_req   = 1'b0;
    bk_color    = 3'b010;
    @(negedge clk);
    check("clear_busy", 32'(busy), 32'd1);
    wait_drain("clear_drained");
    wait_ready("clear_then_accept");

    // shallow line, with first-pixel latency
    for (int i = 0; i < 8; i++) push_px(lx[i], ly[i], 2);
    send_line(2, 3, 9, 5, 2, 1'b0);
    @(negedge clk);
    check("setup_gap_px_valid", 32'(lif.px_valid), 32'd0);
    @(negedge clk);
    check("first_px_latency", 32'(lif.px_valid), 32'd1);
    check("first_px_xy", 32'({lif.px_x, lif.px_y}), 32'({10'd2, 10'd3}));
    wait_drain("shallow_drained");
    wait_ready("shallow_then_accept");

    // steep negative line
    for (int y = 10; y >= 2; y--) push_px(5, y, 6);
    send_line(5, 10, 5, 2, 6, 1'b0);
    wait_drain("steep_drained");
    wait_ready("steep_then_accept");

    // degenerate line: one pixel, back in ACCEPT three cycles after acceptance
    push_px(7, 7, 1);
    send_line(7, 7, 7, 7, 1, 1'b0);
    @(negedge clk);
    check("degen_setup", 32'(lif.px_valid), 32'd0);
    @(negedge clk);
    check("degen_draw", 32'(lif.px_valid), 32'd1);
    @(negedge clk);
    check("degen_back_in_accept", 32'(lif.line_ready), 32'd1);
    check("degen_drained", 32'(exp_q.size()), 32'd0);

    // frame buffer stalls mid-line
    push_px(0, 0, 4);
    push_px(1, 0, 4);
    push_px(2, 1, 4);
    push_px(3, 1, 4);
    send_line(0, 0, 3, 1, 4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      lif.px_ready = pat[i][0];
    end
    lif.px_ready = 1'b1;
    wait_drain("stall_drained");
    wait_ready("stall_then_accept");

    // line crossing the right screen edge
    push_px(6, 0, 3);
    push_px(7, 0, 3);
`ifndef LINE_RASTER_SCREEN_CLIP_EN
    push_px(8, 0, 3);
    push_px(9, 0, 3);
`endif
    send_line(6, 0, 9, 0, 3, 1'b0);
    wait_drain("edge_drained");
    wait_ready("edge_then_accept");

    // last line arrives together with end_of_objects
    push_px(1, 1, 7);
    push_px(2, 1, 7);
    push_px(3, 2, 7);
    send_line(1, 1, 3, 2, 7, 1'b1);
    t = 0;
    while (!raster_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("eoo_raster_done", 32'(raster_done), 32'd1);
    check("eoo_line_first", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("eoo_pulse_one_cycle", 32'(raster_done), 32'd0);
    check("eoo_idle", 32'(state_dbg), 32'(IDLE));
    check("eoo_not_busy", 32'(busy), 32'd0);
    end_of_objects = 1'b0;

    // async reset in the middle of a line
    sb_en = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    send_line(0, 0, 20, 0, 2, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_draw_active", 32'(lif.px_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_px_valid", 32'(lif.px_valid), 32'd0);
    check("async_rst_state", 32'(state_dbg), 32'(IDLE));
    check("async_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(state_dbg), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
